window_5x5_gen: RTL and testbench
=================================

Name: window_5x5_gen

Overview:
- Streaming 5x5 neighbourhood generator placed directly upstream of the DoG sum stage.
- Accepts a raster-order 8-bit pixel stream and buffers four previous image lines in on-chip line buffers.
- Presents a registered 5x5 window plus a valid strobe for every pixel position where the full window lies inside the image.
- The window feeds the DoG sum's 25 window inputs, rows 1..5 by columns 1..5.

Parameters:
IMG_WIDTH, 640, pixels per line (must be >= 5)
IMG_HEIGHT, 480, lines per frame (must be >= 5)
DATA_W, 8, bits per pixel

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
pix_in  in  DATA_W  input pixel, raster order
pix_valid  in  1  pix_in valid this cycle; no backpressure
sof  in  1  start of frame, qualified by pix_valid; marks pixel (0,0)
win  out  25*DATA_W  window; element (r,c) at bits [((r-1)*5+(c-1))*DATA_W +: DATA_W]
win_valid  out  1  win holds a complete in-image window
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (async assert, sync release): col=0, row=0, win=0, win_valid=0, frame_done=0, window shift registers=0. Line-buffer RAM is not cleared; its contents are don't-care.
- Counters advance only on pix_valid=1:
  - col increments, wrapping at IMG_WIDTH-1 to 0.
  - On col wrap, row increments, wrapping at IMG_HEIGHT-1 to 0.
- sof with pix_valid: the pixel is treated as (0,0) and counters reload regardless of their state. This also applies mid-frame: the current frame is aborted with no frame_done.
- A pixel arriving after a wrap without sof is accepted as (0,0) of the next frame.
- Line buffers: four buffers, IMG_WIDTH deep, indexed by col.
  - On each accepted pixel, buffer k (k=1..4) outputs the pixel from row-k at this col and is written with the value buffer k-1 held (buffer 0 = pix_in). This is a cascade.
  - Read-before-write at the same address within one cycle.
- Window: 5 rows x 5 shift registers.
  - On an accepted pixel, every row shifts left by one column: column c takes column c+1.
  - Column 5 is loaded from the vertical tap: row 5 = pix_in, row 4 = buffer1, ..., row 1 = buffer4.
  - Row 1 is the oldest line (row-4), row 5 the current line. Column 1 is the oldest pixel (col-4), column 5 the current pixel.
  - Shift registers hold their value when pix_valid=0.
- win_valid: registered. It is 1 in the cycle after an accepted pixel with row>=4 and col>=4, and 0 otherwise, including every pix_valid=0 cycle.
- Latency is 1 cycle from the pixel at (r,c) to the window whose column 5, row 5 is that pixel. The window centre is (r-2,c-2).
- Windows per frame: (IMG_WIDTH-4)*(IMG_HEIGHT-4).
- Border positions (row<4 or col<4) are never flagged valid. No padding or replication is performed. Stale horizontal data at line starts is therefore never exposed as valid.
- frame_done is registered. It pulses 1 in the same cycle as the final win_valid, following the accepted pixel at (IMG_HEIGHT-1, IMG_WIDTH-1).
- Stalls (pix_valid gaps) of any length, including across line and frame boundaries, do not alter the output sequence of valid windows.
- Reset mid-frame: outputs go to 0 immediately. The next frame must start with sof or at counter position (0,0). The first 4 lines after reset are never windowed, so old RAM contents are never exposed.

Test Plan:
1. IMG_WIDTH=8, IMG_HEIGHT=6; stream one frame, pixel=(row<<4)|col, pix_valid=1 continuously, sof on first pixel. Required:
   - First win_valid 1 cycle after pixel (4,4), with win(1,1)=0x00, win(3,3)=0x22, win(5,5)=0x44.
   - Exactly 8 valid windows, last with win(5,5)=0x57.
   - frame_done coincides with the last win_valid.
2. Same frame with pix_valid toggled 1,0,0,1 pseudo-randomly. Required: identical sequence of 8 win values; win_valid never 1 in the cycle after pix_valid=0.
3. Two back-to-back frames with sof on the second only. Required: 16 valid windows total, 2 frame_done pulses; the second frame's first window equals the first frame's first window.
4. sof asserted at pixel (3,5) of frame 1, then a full frame. Required: no frame_done for the aborted frame; first win_valid 1 cycle after the new frame's pixel (4,4), with win(3,3)=0x22.
5. rst_n low for 2 cycles mid-row 4. Required: win=0, win_valid=0, frame_done=0 asynchronously. A subsequent full frame gives exactly 8 correct windows.

Source files
------------

// File: rtl/window_5x5_gen.sv
// -----------------------------------------------------------------------------
// window_5x5_gen
// Streaming 5x5 neighbourhood generator for a raster-order pixel stream.
// Four cascaded line buffers supply the vertical taps. A 5x5 bank of shift
// registers holds the window. win_valid flags only windows that lie fully
// inside the image.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   pix_in     - input pixel, raster order
//   pix_valid  - pix_in valid this cycle (no backpressure)
//   sof        - start of frame, qualified by pix_valid; marks pixel (0,0)
//   win        - 5x5 window, element (r,c) at [((r-1)*5+(c-1))*DATA_W +: DATA_W]
//   win_valid  - win holds a complete in-image window
//   frame_done - one-cycle pulse with the final window of a frame
// -----------------------------------------------------------------------------
module window_5x5_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int DATA_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      pix_in,
    input  logic                   pix_valid,
    input  logic                   sof,
    output logic [25*DATA_W-1:0]   win,
    output logic                   win_valid,
    output logic                   frame_done
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]     col, curCol;
    logic [RW-1:0]     row, curRow;
    logic              lastCol, lastRow;
    logic              inWindow;

    logic [DATA_W-1:0] lineBuf [4][IMG_WIDTH];
    logic [DATA_W-1:0] tap     [4];
    logic [DATA_W-1:0] winReg  [5][5];

    // sof overrides whatever position the counters hold, so an aborted
    // frame simply restarts at (0,0).
    always_comb begin
        curCol   = sof ? '0 : col;
        curRow   = sof ? '0 : row;
        lastCol  = (curCol == CW'(IMG_WIDTH - 1));
        lastRow  = (curRow == RW'(IMG_HEIGHT - 1));
        inWindow = (curRow >= RW'(4)) && (curCol >= CW'(4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            col <= lastCol ? '0 : curCol + CW'(1);
            if (lastCol)
                row <= lastRow ? '0 : curRow + RW'(1);
            else
                row <= curRow;
        end
    end

    // tap[k] is the pixel from row-(k+1) at the current column; the read
    // happens before this cycle's write to the same address.
    always_comb begin
        for (int k = 0; k < 4; k++)
            tap[k] = lineBuf[k][curCol];
    end

    // Line buffer RAM is not reset: the first four lines of a frame are
    // never windowed, so stale contents never reach a valid output.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lineBuf[0][curCol] <= pix_in;
            for (int k = 1; k < 4; k++)
                lineBuf[k][curCol] <= tap[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    winReg[r][c] <= '0;
        end else if (pix_valid) begin
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 4; c++)
                    winReg[r][c] <= winReg[r][c+1];
            // Newest column: bottom row is the live pixel, top row the oldest line.
            winReg[4][4] <= pix_in;
            winReg[3][4] <= tap[0];
            winReg[2][4] <= tap[1];
            winReg[1][4] <= tap[2];
            winReg[0][4] <= tap[3];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pix_valid && inWindow;
            frame_done <= pix_valid && lastRow && lastCol;
        end
    end

    for (genvar gr = 0; gr < 5; gr++) begin : gRow
        for (genvar gc = 0; gc < 5; gc++) begin : gCol
            assign win[(gr*5+gc)*DATA_W +: DATA_W] = winReg[gr][gc];
        end
    end

endmodule

// File: tb/tb_window_5x5_gen.sv
module tb_window_5x5_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int WB = 25*DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] pix_in = '0;
    logic          pix_valid = 1'b0;
    logic          sof = 1'b0;
    logic [WB-1:0] win;
    logic          win_valid;
    logic          frame_done;

    window_5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .sof(sof), .win(win), .win_valid(win_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: image memory plus raster position.
    logic [DW-1:0] img [H][W];
    int            mRow = 0, mCol = 0;
    logic          expValid = 1'b0, expDone = 1'b0;
    logic [WB-1:0] expWin = '0;

    // DUT-observed results
    logic [WB-1:0] capQ [$];
    int            doneCnt = 0;

    typedef struct {
        int            winIdx;
        int            r;
        int            c;
        logic [DW-1:0] expVal;
    } vec_t;

    function automatic logic [DW-1:0] el(input logic [WB-1:0] w, input int r, input int c);
        return w[((r-1)*5+(c-1))*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [WB-1:0] act, input logic [WB-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model(input bit v, input bit s, input logic [DW-1:0] p);
        int cr, cc;
        expValid = 1'b0;
        expDone  = 1'b0;
        if (v) begin
            cr = s ? 0 : mRow;
            cc = s ? 0 : mCol;
            img[cr][cc] = p;
            if (cr >= 4 && cc >= 4) begin
                expValid = 1'b1;
                for (int r = 1; r <= 5; r++)
                    for (int c = 1; c <= 5; c++)
                        expWin[((r-1)*5+(c-1))*DW +: DW] = img[cr-5+r][cc-5+c];
            end
            expDone = (cr == H-1) && (cc == W-1);
            mCol = (cc == W-1) ? 0 : cc + 1;
            mRow = (cc == W-1) ? ((cr == H-1) ? 0 : cr + 1) : cr;
        end
    endtask

    task automatic cycle(input bit v, input bit s, input logic [DW-1:0] p);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        model(v, s, p);
        @(posedge clk);
        #1;
        chk("win_valid", WB'(win_valid), WB'(expValid));
        chk("frame_done", WB'(frame_done), WB'(expDone));
        if (expValid)
            chk("win", win, expWin);
        if (win_valid) capQ.push_back(win);
        if (frame_done) doneCnt++;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    // Streams the first nPix pixels of a frame.
    task automatic streamFrame(input bit useSof, input int nPix, input bit randData, input bit gaps);
        int r, c, g;
        logic [DW-1:0] p;
        for (int i = 0; i < nPix; i++) begin
            r = i / W;
            c = i % W;
            p = randData ? DW'($urandom) : DW'((r << 4) | c);
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) cycle(1'b0, 1'b0, DW'($urandom));
            end
            cycle(1'b1, useSof && (i == 0), p);
        end
        cycle(1'b0, 1'b0, '0);
    endtask

    vec_t tbl [7];
    logic [WB-1:0] ref1 [$];
    logic [WB-1:0] first1, firstSecond;

    initial begin
        tbl[0] = '{0, 1, 1, 8'h00};
        tbl[1] = '{0, 3, 3, 8'h22};
        tbl[2] = '{0, 5, 5, 8'h44};
        tbl[3] = '{0, 1, 5, 8'h04};
        tbl[4] = '{0, 5, 1, 8'h40};
        tbl[5] = '{7, 5, 5, 8'h57};
        tbl[6] = '{7, 1, 1, 8'h13};

        repeat (2) @(posedge clk);
        #1;
        chk("reset win", win, '0);
        chk("reset win_valid", WB'(win_valid), '0);
        chk("reset frame_done", WB'(frame_done), '0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: continuous frame, pattern data
        capQ.delete(); doneCnt = 0;
        streamFrame(1'b1, W*H, 1'b0, 1'b0);
        chk("t1 window count", WB'(capQ.size()), WB'(8));
        chk("t1 frame_done count", WB'(doneCnt), WB'(1));
        if (capQ.size() == 8) begin
            for (int i = 0; i < 7; i++)
                chk($sformatf("t1 win%0d(%0d,%0d)", tbl[i].winIdx, tbl[i].r, tbl[i].c),
                    WB'(el(capQ[tbl[i].winIdx], tbl[i].r, tbl[i].c)), WB'(tbl[i].expVal));
        end
        ref1 = capQ;

        // 2: same frame with random gaps
        capQ.delete(); doneCnt = 0;
        streamFrame(1'b1, W*H, 1'b0, 1'b1);
        chk("t2 window count", WB'(capQ.size()), WB'(8));
        if (capQ.size() == 8 && ref1.size() == 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("t2 win%0d vs t1", i), capQ[i], ref1[i]);

        // 3: back-to-back frames, sof on the second only
        capQ.delete(); doneCnt = 0;
        streamFrame(1'b0, W*H, 1'b0, 1'b0);
        streamFrame(1'b1, W*H, 1'b0, 1'b0);
        chk("t3 window count", WB'(capQ.size()), WB'(16));
        chk("t3 frame_done count", WB'(doneCnt), WB'(2));
        if (capQ.size() == 16) begin
            first1 = capQ[0];
            firstSecond = capQ[8];
            chk("t3 first windows equal", firstSecond, first1);
        end

        // 4: abort at (3,5) with sof, then full frame
        capQ.delete(); doneCnt = 0;
        streamFrame(1'b1, 3*W+5, 1'b0, 1'b0);
        chk("t4 aborted frame_done", WB'(doneCnt), WB'(0));
        chk("t4 aborted windows", WB'(capQ.size()), WB'(0));
        streamFrame(1'b1, W*H, 1'b0, 1'b0);
        chk("t4 window count", WB'(capQ.size()), WB'(8));
        chk("t4 frame_done count", WB'(doneCnt), WB'(1));
        if (capQ.size() > 0)
            chk("t4 first win(3,3)", WB'(el(capQ[0], 3, 3)), WB'(8'h22));

        // 5: reset in row 4 while a window is valid
        capQ.delete(); doneCnt = 0;
        streamFrame(1'b1, 4*W+6, 1'b1, 1'b0);
        pix_valid = 1'b1; pix_in = 8'hAB;
        model(1'b1, 1'b0, 8'hAB);
        @(posedge clk); #1;
        chk("t5 pre-reset win_valid", WB'(win_valid), WB'(1));
        pix_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5 async win", win, '0);
        chk("t5 async win_valid", WB'(win_valid), '0);
        chk("t5 async frame_done", WB'(frame_done), '0);
        mRow = 0; mCol = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        capQ.delete(); doneCnt = 0;
        streamFrame(1'b1, W*H, 1'b0, 1'b0);
        chk("t5 window count", WB'(capQ.size()), WB'(8));
        if (capQ.size() == 8 && ref1.size() == 8)
            for (int i = 0; i < 8; i++)
                chk($sformatf("t5 win%0d vs t1", i), capQ[i], ref1[i]);

        // 6: random data and random gaps over several frames
        capQ.delete(); doneCnt = 0;
        for (int f = 0; f < 4; f++)
            streamFrame(f[0], W*H, 1'b1, 1'b1);
        chk("t6 window count", WB'(capQ.size()), WB'(32));
        chk("t6 frame_done count", WB'(doneCnt), WB'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
